// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe input-conditioning stage.
package tictactoe_pkg;

    localparam int NUM_CELLS = 9;

    typedef logic [3:0] cell_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        WAIT_RELEASE
    } in_state_t;

    typedef struct packed {
        logic      valid;
        cell_idx_t idx;
    } onehot_dec_t;

    // Decode the switch bank: valid only when exactly one bit is set.
    // idx is forced to 0 when the pattern is not one-hot.
    function automatic onehot_dec_t onehot9_to_idx(input logic [NUM_CELLS-1:0] v);
        onehot_dec_t r;
        int unsigned ones;
        r.valid = 1'b0;
        r.idx   = '0;
        ones    = 0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (v[i]) begin
                ones  = ones + 1;
                r.idx = cell_idx_t'(i);
            end
        end
        r.valid = (ones == 1);
        if (!r.valid) begin
            r.idx = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for one active-low key.
// key_db is the accepted level; press is a one-cycle pulse on its 1->0 edge.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_db,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_meta_p0;
    logic             key_sync_p1;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clock domain; released level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_p0 <= 1'b1;
            key_sync_p1 <= 1'b1;
        end else begin
            key_meta_p0 <= key_n;
            key_sync_p1 <= key_meta_p0;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            key_db <= 1'b1;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync_p1 != key_db) begin
                if (cnt == CNT_MAX) begin
                    key_db <= key_sync_p1;
                    cnt    <= '0;
                    press  <= ~key_sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tictactoe_input_ctrl.sv
// Input conditioning for the tic-tac-toe game FSM: debounced keys, one-hot
// switch validation and a valid/ack move request plus a game-reset pulse.
module tictactoe_input_ctrl
    import tictactoe_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 rst,
    input  logic                 key_select_n,
    input  logic                 key_reset_n,
    input  logic [NUM_CELLS-1:0] sw,
    output logic                 move_valid,
    output cell_idx_t            move_idx,
    input  logic                 move_ack,
    output logic                 game_reset,
    output logic                 bad_move
);

    logic                 sel_db;
    logic                 sel_press;
    logic                 rst_db;
    logic                 rst_press;
    logic [NUM_CELLS-1:0] sw_meta_p0;
    logic [NUM_CELLS-1:0] sw_sync_p1;
    onehot_dec_t          sw_dec;

    in_state_t            state;
    in_state_t            state_nxt;
    logic                 move_valid_nxt;
    cell_idx_t            move_idx_nxt;
    logic                 game_reset_nxt;
    logic                 bad_move_nxt;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sel_db (
        .clk    (MAX10_CLK1_50),
        .rst    (rst),
        .key_n  (key_select_n),
        .key_db (sel_db),
        .press  (sel_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_rst_db (
        .clk    (MAX10_CLK1_50),
        .rst    (rst),
        .key_n  (key_reset_n),
        .key_db (rst_db),
        .press  (rst_press)
    );

    // Synchronise the switch bank; it is only sampled on a select press.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            sw_meta_p0 <= '0;
            sw_sync_p1 <= '0;
        end else begin
            sw_meta_p0 <= sw;
            sw_sync_p1 <= sw_meta_p0;
        end
    end

    assign sw_dec = onehot9_to_idx(sw_sync_p1);

    // Register the FSM state together with its registered outputs.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            state      <= IDLE;
            move_valid <= 1'b0;
            move_idx   <= '0;
            game_reset <= 1'b0;
            bad_move   <= 1'b0;
        end else begin
            state      <= state_nxt;
            move_valid <= move_valid_nxt;
            move_idx   <= move_idx_nxt;
            game_reset <= game_reset_nxt;
            bad_move   <= bad_move_nxt;
        end
    end

    // Next-state logic; a reset-key press overrides everything else.
    always_comb begin
        state_nxt      = state;
        move_valid_nxt = move_valid;
        move_idx_nxt   = move_idx;
        game_reset_nxt = 1'b0;
        bad_move_nxt   = 1'b0;
        if (rst_press) begin
            game_reset_nxt = 1'b1;
            move_valid_nxt = 1'b0;
            move_idx_nxt   = '0;
            state_nxt      = sel_db ? IDLE : WAIT_RELEASE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_press) begin
                        if (sw_dec.valid) begin
                            move_valid_nxt = 1'b1;
                            move_idx_nxt   = sw_dec.idx;
                            state_nxt      = PENDING;
                        end else begin
                            bad_move_nxt = 1'b1;
                            state_nxt    = WAIT_RELEASE;
                        end
                    end
                end
                PENDING: begin
                    if (move_ack) begin
                        move_valid_nxt = 1'b0;
                        move_idx_nxt   = '0;
                        state_nxt      = WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (sel_db) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tictactoe_input_ctrl.sv
// Self-checking bench for tictactoe_input_ctrl with a short debounce count.
module tb_tictactoe_input_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_select_n = 1'b1;
    logic       key_reset_n = 1'b1;
    logic [8:0] sw = '0;
    logic       move_valid;
    logic [3:0] move_idx;
    logic       move_ack = 1'b0;
    logic       game_reset;
    logic       bad_move;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw sample histories (index k = k+1 edges ago).
    bit         hs [0:D+1];
    bit         hr [0:D+1];
    logic [8:0] hw [0:1];
    bit         dbs, dbr, prs, prr;
    bit         m_valid, m_gr, m_bm;
    int         m_idx;
    int         st;      // 0 idle, 1 request outstanding, 2 waiting for release

    // Per-scenario statistics.
    int  cyc, mv_rises, bm_cnt, gr_cnt, first_mv, first_bm, first_gr;
    bit  prev_mv = 1'b0;

    tictactoe_input_ctrl #(
        .CLK_HZ(50000000),
        .DEBOUNCE_MS(10),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .key_select_n  (key_select_n),
        .key_reset_n   (key_reset_n),
        .sw            (sw),
        .move_valid    (move_valid),
        .move_idx      (move_idx),
        .move_ack      (move_ack),
        .game_reset    (game_reset),
        .bad_move      (bad_move)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A key level is accepted once the last D+1 synchronised samples all
    // disagree with the accepted level; the game logic reacts one edge later.
    task automatic model_edge();
        bit all_s, all_r;
        if (rst) begin
            for (int k = 0; k <= D + 1; k++) begin
                hs[k] = 1'b1;
                hr[k] = 1'b1;
            end
            hw[0] = '0; hw[1] = '0;
            dbs = 1'b1; dbr = 1'b1; prs = 1'b0; prr = 1'b0;
            m_valid = 1'b0; m_idx = 0; m_gr = 1'b0; m_bm = 1'b0; st = 0;
        end else begin
            m_gr = 1'b0;
            m_bm = 1'b0;
            if (prr) begin
                m_gr = 1'b1; m_valid = 1'b0; m_idx = 0;
                st = dbs ? 0 : 2;
            end else if (st == 0) begin
                if (prs) begin
                    if ($countones(hw[1]) == 1) begin
                        m_valid = 1'b1; m_idx = $clog2(hw[1]); st = 1;
                    end else begin
                        m_bm = 1'b1; st = 2;
                    end
                end
            end else if (st == 1) begin
                if (move_ack) begin
                    m_valid = 1'b0; m_idx = 0; st = 2;
                end
            end else if (dbs) begin
                st = 0;
            end
            all_s = 1'b1;
            all_r = 1'b1;
            for (int k = 1; k <= D + 1; k++) begin
                if (hs[k] == dbs) all_s = 1'b0;
                if (hr[k] == dbr) all_r = 1'b0;
            end
            prs = all_s && dbs;
            prr = all_r && dbr;
            if (all_s) dbs = ~dbs;
            if (all_r) dbr = ~dbr;
            for (int k = D + 1; k >= 1; k--) begin
                hs[k] = hs[k-1];
                hr[k] = hr[k-1];
            end
            hs[0] = key_select_n;
            hr[0] = key_reset_n;
            hw[1] = hw[0];
            hw[0] = sw;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("move_valid", int'(move_valid), int'(m_valid));
        check("move_idx", int'(move_idx), m_idx);
        check("game_reset", int'(game_reset), int'(m_gr));
        check("bad_move", int'(bad_move), int'(m_bm));
        if (move_valid && !prev_mv) begin
            mv_rises++;
            if (first_mv < 0) first_mv = cyc;
        end
        if (bad_move) begin
            bm_cnt++;
            if (first_bm < 0) first_bm = cyc;
        end
        if (game_reset) begin
            gr_cnt++;
            if (first_gr < 0) first_gr = cyc;
        end
        prev_mv = move_valid;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_stats();
        cyc = 0; mv_rises = 0; bm_cnt = 0; gr_cnt = 0;
        first_mv = -1; first_bm = -1; first_gr = -1;
    endtask

    initial begin
        clr_stats();
        // Reset state
        rst = 1'b1;
        run(2);
        check("reset_valid", int'(move_valid), 0);
        check("reset_idx", int'(move_idx), 0);
        rst = 1'b0;
        run(3);

        // Valid move: latency, hold, ack, no auto-repeat
        clr_stats();
        sw = 9'b000010000;
        key_select_n = 1'b0;
        run(20);
        check("s1_first_valid_cycle", first_mv, 7);
        check("s1_idx", int'(move_idx), 4);
        move_ack = 1'b1;
        run(1);
        move_ack = 1'b0;
        check("s1_drop_after_ack", int'(move_valid), 0);
        run(8);
        key_select_n = 1'b1;
        run(10);
        check("s1_single_request", mv_rises, 1);

        // Not one-hot
        clr_stats();
        sw = 9'b000000011;
        key_select_n = 1'b0;
        run(10);
        key_select_n = 1'b1;
        run(10);
        check("s2_bad_cycle", first_bm, 7);
        check("s2_bad_count", bm_cnt, 1);
        check("s2_no_valid", mv_rises, 0);

        // Glitch
        clr_stats();
        sw = 9'b000000100;
        key_select_n = 1'b0;
        run(3);
        key_select_n = 1'b1;
        run(12);
        check("s3_glitch_events", mv_rises + bm_cnt, 0);

        // Switch change and second press while a request is outstanding
        clr_stats();
        sw = 9'b100000000;
        key_select_n = 1'b0;
        run(10);
        key_select_n = 1'b1;
        run(10);
        sw = 9'b000000001;
        key_select_n = 1'b0;
        run(10);
        key_select_n = 1'b1;
        run(10);
        check("s4_idx_held", int'(move_idx), 8);
        check("s4_one_request", mv_rises, 1);
        move_ack = 1'b1;
        run(1);
        move_ack = 1'b0;
        run(3);

        // Reset key and select together
        clr_stats();
        sw = 9'b000001000;
        key_select_n = 1'b0;
        key_reset_n = 1'b0;
        run(10);
        key_select_n = 1'b1;
        key_reset_n = 1'b1;
        run(10);
        check("s5_reset_cycle", first_gr, 7);
        check("s5_reset_count", gr_cnt, 1);
        check("s5_no_valid", mv_rises, 0);
        check("s5_no_bad", bm_cnt, 0);

        // rst mid-handshake
        clr_stats();
        sw = 9'b000100000;
        key_select_n = 1'b0;
        run(10);
        check("s6_pending", int'(move_valid), 1);
        key_select_n = 1'b1;
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("s6_valid_cleared", int'(move_valid), 0);
        check("s6_idx_cleared", int'(move_idx), 0);
        run(10);
        check("s6_quiet_after", int'(move_valid) + int'(game_reset) + int'(bad_move), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) key_select_n = ~key_select_n;
            if ($urandom_range(11) == 0) key_reset_n = ~key_reset_n;
            if ($urandom_range(15) == 0)
                sw = ($urandom_range(3) == 0) ? 9'($urandom) : (9'b1 << $urandom_range(8));
            move_ack = ($urandom_range(3) == 0);
            rst = ($urandom_range(199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
